// File: rtl/control_sequencer_module_if.sv
// Control-sequencer bus bundle: run/opcode/flags in, ie/oe/step strobes and status out.
interface control_sequencer_module_if;
  logic       run;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;

  logic pc_ie, pc_oe, pc_step;
  logic mar_ie;
  logic ram_ie, ram_oe;
  logic ir_ie, ir_oe;
  logic a_ie, a_oe;
  logic b_ie;
  logic alu_oe, alu_sub;
  logic flags_ie;
  logic out_ie;

  logic       halted;
  logic [2:0] tstate;

  // Sequencer side
  modport master (
    input  run, opcode, flag_c, flag_z,
    output pc_ie, pc_oe, pc_step, mar_ie, ram_ie, ram_oe, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie,
           halted, tstate
  );

  // Register-module / controller side
  modport slave (
    output run, opcode, flag_c, flag_z,
    input  pc_ie, pc_oe, pc_step, mar_ie, ram_ie, ram_oe, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie,
           halted, tstate
  );
endinterface

// File: rtl/control_sequencer_module.sv
// Microstep controller for the 8-bit bus machine: 5-step T-state counter plus
// combinational strobe decode of (tstate, opcode). Strobes are gated by
// run & ~halted & rst so a paused or reset machine never latches anything.
// Optional feature macro: COND_JUMP_EN (adds JC 0x7 / JZ 0x8).
module control_sequencer_module #(
  parameter logic [3:0] OUT_OPCODE = 4'hE,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input logic                        clk,
  input logic                        rst,
  control_sequencer_module_if.master bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    strobe_en;

  logic pc_ie, pc_oe, pc_step, mar_ie, ram_ie, ram_oe, ir_ie, ir_oe;
  logic a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie;

`ifndef COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = bus.flag_c ^ bus.flag_z;
`endif

  // State register: T-state counter and halt latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next state: advance while running and not halted; HLT freezes in T2
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (bus.run && !halted_q) begin
      if (state_q == T2 && bus.opcode == HLT_OPCODE) begin
        halted_d = 1'b1;
      end else begin
        case (state_q)
          T0:      state_d = T1;
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          default: state_d = T0;
        endcase
      end
    end
  end

  assign strobe_en = bus.run & ~halted_q & rst;

  // Strobe decode: fetch in T0/T1, opcode-specific execute in T2..T4
  always_comb begin
    pc_ie    = 1'b0;
    pc_oe    = 1'b0;
    pc_step  = 1'b0;
    mar_ie   = 1'b0;
    ram_ie   = 1'b0;
    ram_oe   = 1'b0;
    ir_ie    = 1'b0;
    ir_oe    = 1'b0;
    a_ie     = 1'b0;
    a_oe     = 1'b0;
    b_ie     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    flags_ie = 1'b0;
    out_ie   = 1'b0;
    if (strobe_en) begin
      if (state_q == T0) begin
        pc_oe  = 1'b1;
        mar_ie = 1'b1;
      end else if (state_q == T1) begin
        ram_oe  = 1'b1;
        ir_ie   = 1'b1;
        pc_step = 1'b1;
      end else if (bus.opcode == HLT_OPCODE) begin
        // HLT issues nothing; the halt latch is set by the next-state logic
      end else if (bus.opcode == OUT_OPCODE) begin
        if (state_q == T2) begin
          a_oe   = 1'b1;
          out_ie = 1'b1;
        end
      end else begin
        case (bus.opcode)
          4'h1: begin // LDA
            if (state_q == T2) begin ir_oe = 1'b1; mar_ie = 1'b1; end
            if (state_q == T3) begin ram_oe = 1'b1; a_ie = 1'b1; end
          end
          4'h2, 4'h3: begin // ADD / SUB
            if (state_q == T2) begin ir_oe = 1'b1; mar_ie = 1'b1; end
            if (state_q == T3) begin ram_oe = 1'b1; b_ie = 1'b1; end
            if (state_q == T4) begin
              alu_oe   = 1'b1;
              a_ie     = 1'b1;
              flags_ie = 1'b1;
              alu_sub  = (bus.opcode == 4'h3);
            end
          end
          4'h4: begin // STA
            if (state_q == T2) begin ir_oe = 1'b1; mar_ie = 1'b1; end
            if (state_q == T3) begin a_oe = 1'b1; ram_ie = 1'b1; end
          end
          4'h5: begin // LDI
            if (state_q == T2) begin ir_oe = 1'b1; a_ie = 1'b1; end
          end
          4'h6: begin // JMP
            if (state_q == T2) begin ir_oe = 1'b1; pc_ie = 1'b1; end
          end
`ifdef COND_JUMP_EN
          4'h7: begin // JC
            if (state_q == T2 && bus.flag_c) begin ir_oe = 1'b1; pc_ie = 1'b1; end
          end
          4'h8: begin // JZ
            if (state_q == T2 && bus.flag_z) begin ir_oe = 1'b1; pc_ie = 1'b1; end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.pc_ie    = pc_ie;
  assign bus.pc_oe    = pc_oe;
  assign bus.pc_step  = pc_step;
  assign bus.mar_ie   = mar_ie;
  assign bus.ram_ie   = ram_ie;
  assign bus.ram_oe   = ram_oe;
  assign bus.ir_ie    = ir_ie;
  assign bus.ir_oe    = ir_oe;
  assign bus.a_ie     = a_ie;
  assign bus.a_oe     = a_oe;
  assign bus.b_ie     = b_ie;
  assign bus.alu_oe   = alu_oe;
  assign bus.alu_sub  = alu_sub;
  assign bus.flags_ie = flags_ie;
  assign bus.out_ie   = out_ie;
  assign bus.halted   = halted_q;
  assign bus.tstate   = 3'(state_q);

endmodule
